// File: rtl/fpmul_result_collector_pkg.sv
// Shared types and constants for the FP multiplier result collector.
package fpmul_result_collector_pkg;

  localparam int unsigned ST_ZERO    = 0;
  localparam int unsigned ST_INF     = 1;
  localparam int unsigned ST_NAN     = 2;
  localparam int unsigned ST_TINY    = 3;
  localparam int unsigned ST_HUGE    = 4;
  localparam int unsigned ST_INEXACT = 5;

  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] z;
    logic [0:7]  status;
  } fpmul_result_t;

endpackage

// File: rtl/fpmul_result_collector_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module fpmul_result_collector_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fpmul_result_collector.sv
// Result FIFO plus saturating status counters behind the FP multiplier.
// Optional build macro FPMUL_COLLECT_NAN_CANON_EN canonicalises stored NaN results.
module fpmul_result_collector
  import fpmul_result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_z,
  input  logic [0:7]               in_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_z,
  output logic [0:7]               out_status,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic [2:0]               cnt_sel,
  output logic [CNT_W-1:0]         cnt_q,
  input  logic                     clr
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  fpmul_result_t    r_mem [DEPTH];
  fpmul_result_t    r_head;
  fpmul_result_t    w_head_nxt;
  fpmul_result_t    w_push_data;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_nxt;
  logic             r_out_valid;
  logic             r_overflow;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt [8];

  assign w_full = (r_fill == FILL_W'(DEPTH));
  assign w_pop  = r_out_valid & out_ready;
  assign w_push = in_valid & (~w_full | w_pop);
  assign w_drop = in_valid & w_full & ~w_pop;

  always_comb begin
    w_push_data.z      = in_z;
    w_push_data.status = in_status;
`ifdef FPMUL_COLLECT_NAN_CANON_EN
    if (in_status[ST_NAN]) begin
      w_push_data.z = CANON_QNAN;
    end
`endif
  end

  // Next head is forwarded from the push when the FIFO is otherwise empty after the pop.
  always_comb begin
    w_rd_nxt   = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    w_fill_nxt = r_fill;
    w_head_nxt = '0;
    case ({w_push, w_pop})
      2'b10:   w_fill_nxt = r_fill + FILL_W'(1);
      2'b01:   w_fill_nxt = r_fill - FILL_W'(1);
      default: w_fill_nxt = r_fill;
    endcase
    if (w_fill_nxt != '0) begin
      if (w_push && (r_wr_ptr == w_rd_nxt)) begin
        w_head_nxt = w_push_data;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= w_rd_nxt;
      r_fill      <= w_fill_nxt;
      r_out_valid <= (w_fill_nxt != '0);
      r_head      <= w_head_nxt;
      if (clr) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_z      = r_head.z;
  assign out_status = r_head.status;
  assign fill       = r_fill;
  assign overflow   = r_overflow;

  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_zero (
    .clk(clk), .rst_n(rst_n), .inc(in_valid & in_status[ST_ZERO]), .clr(clr), .q(w_cnt[0])
  );
  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_inf (
    .clk(clk), .rst_n(rst_n), .inc(in_valid & in_status[ST_INF]), .clr(clr), .q(w_cnt[1])
  );
  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_nan (
    .clk(clk), .rst_n(rst_n), .inc(in_valid & in_status[ST_NAN]), .clr(clr), .q(w_cnt[2])
  );
  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_tiny (
    .clk(clk), .rst_n(rst_n), .inc(in_valid & in_status[ST_TINY]), .clr(clr), .q(w_cnt[3])
  );
  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_huge (
    .clk(clk), .rst_n(rst_n), .inc(in_valid & in_status[ST_HUGE]), .clr(clr), .q(w_cnt[4])
  );
  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_inexact (
    .clk(clk), .rst_n(rst_n), .inc(in_valid & in_status[ST_INEXACT]), .clr(clr), .q(w_cnt[5])
  );
  // Counts every valid result, whether it was stored or dropped.
  fpmul_result_collector_sat_counter #(.W(CNT_W)) u_cnt_valid (
    .clk(clk), .rst_n(rst_n), .inc(in_valid), .clr(clr), .q(w_cnt[6])
  );
  assign w_cnt[7] = '0;

  assign cnt_q = w_cnt[cnt_sel];

endmodule

// File: tb/tb_fpmul_result_collector.sv
// Directed vector bench for fpmul_result_collector (DEPTH=4, CNT_W=4).
module tb_fpmul_result_collector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_z;
  logic [0:7]  in_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [0:7]  out_status;
  logic [2:0]  fill;
  logic        overflow;
  logic [2:0]  cnt_sel;
  logic [3:0]  cnt_q;
  logic        clr;

  int errors = 0;
  int checks = 0;

  fpmul_result_collector #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_z(in_z), .in_status(in_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
    .fill(fill), .overflow(overflow), .cnt_sel(cnt_sel), .cnt_q(cnt_q), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] iz;
    logic [0:7]  ist;
    logic        rdy;
    logic        cl;
    logic [2:0]  sel;
    logic        ev;
    logic [31:0] ez;
    logic [0:7]  est;
    logic [2:0]  efill;
    logic        eov;
    logic [3:0]  ecnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

`ifdef FPMUL_COLLECT_NAN_CANON_EN
  localparam logic [31:0] NAN_EXP = 32'h7FC0_0000;
`else
  localparam logic [31:0] NAN_EXP = 32'h7FC0_0001;
`endif

  function automatic vec_t mk(logic iv, logic [31:0] iz, logic [0:7] ist, logic rdy, logic cl,
                              logic [2:0] sel, logic ev, logic [31:0] ez, logic [0:7] est,
                              logic [2:0] efill, logic eov, logic [3:0] ecnt);
    vec_t v;
    v.iv = iv; v.iz = iz; v.ist = ist; v.rdy = rdy; v.cl = cl; v.sel = sel;
    v.ev = ev; v.ez = ez; v.est = est; v.efill = efill; v.eov = eov; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] iz, input logic [0:7] ist,
                       input logic rdy, input logic cl, input logic [2:0] sel);
    in_valid = iv; in_z = iz; in_status = ist; out_ready = rdy; clr = cl; cnt_sel = sel;
  endtask

  task automatic apply(input int idx, input vec_t v);
    drive(v.iv, v.iz, v.ist, v.rdy, v.cl, v.sel);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.ev));
    chk($sformatf("v%0d out_z", idx), out_z, v.ez);
    chk($sformatf("v%0d out_status", idx), 32'(out_status), 32'(v.est));
    chk($sformatf("v%0d fill", idx), 32'(fill), 32'(v.efill));
    chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.eov));
    chk($sformatf("v%0d cnt_q", idx), 32'(cnt_q), 32'(v.ecnt));
  endtask

  initial begin
    // in/out fields: iv iz ist rdy clr sel | valid z status fill ov cnt
    vecs[0]  = mk(1, 32'h3F80_0000, 8'b00000000, 0, 0, 3'd6, 1, 32'h3F80_0000, 8'b00000000, 3'd1, 0, 4'd1);
    vecs[1]  = mk(1, 32'h7F80_0000, 8'b01001000, 0, 0, 3'd1, 1, 32'h3F80_0000, 8'b00000000, 3'd2, 0, 4'd1);
    vecs[2]  = mk(1, 32'h0000_0000, 8'b10000000, 0, 0, 3'd0, 1, 32'h3F80_0000, 8'b00000000, 3'd3, 0, 4'd1);
    vecs[3]  = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd4, 1, 32'h7F80_0000, 8'b01001000, 3'd2, 0, 4'd1);
    vecs[4]  = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd6, 1, 32'h0000_0000, 8'b10000000, 3'd1, 0, 4'd3);
    vecs[5]  = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd3, 0, 32'h0000_0000, 8'b00000000, 3'd0, 0, 4'd0);
    vecs[6]  = mk(0, 32'h0,         8'b00000000, 0, 0, 3'd7, 0, 32'h0000_0000, 8'b00000000, 3'd0, 0, 4'd0);
    vecs[7]  = mk(1, 32'h4000_0001, 8'b00000000, 0, 0, 3'd6, 1, 32'h4000_0001, 8'b00000000, 3'd1, 0, 4'd4);
    vecs[8]  = mk(1, 32'h4000_0002, 8'b00000000, 0, 0, 3'd6, 1, 32'h4000_0001, 8'b00000000, 3'd2, 0, 4'd5);
    vecs[9]  = mk(1, 32'h4000_0003, 8'b00000000, 0, 0, 3'd6, 1, 32'h4000_0001, 8'b00000000, 3'd3, 0, 4'd6);
    vecs[10] = mk(1, 32'h4000_0004, 8'b00000000, 0, 0, 3'd6, 1, 32'h4000_0001, 8'b00000000, 3'd4, 0, 4'd7);
    vecs[11] = mk(1, 32'h4000_0005, 8'b00000000, 0, 0, 3'd6, 1, 32'h4000_0001, 8'b00000000, 3'd4, 1, 4'd8);
    vecs[12] = mk(0, 32'h0,         8'b00000000, 0, 1, 3'd6, 1, 32'h4000_0001, 8'b00000000, 3'd4, 0, 4'd0);
    vecs[13] = mk(1, 32'h4000_0006, 8'b00000000, 1, 0, 3'd6, 1, 32'h4000_0002, 8'b00000000, 3'd4, 0, 4'd1);
    vecs[14] = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd6, 1, 32'h4000_0003, 8'b00000000, 3'd3, 0, 4'd1);
    vecs[15] = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd6, 1, 32'h4000_0004, 8'b00000000, 3'd2, 0, 4'd1);
    vecs[16] = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd6, 1, 32'h4000_0006, 8'b00000000, 3'd1, 0, 4'd1);
    vecs[17] = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd6, 0, 32'h0000_0000, 8'b00000000, 3'd0, 0, 4'd1);
    vecs[18] = mk(1, 32'h7FC0_0001, 8'b00100000, 0, 0, 3'd2, 1, NAN_EXP,       8'b00100000, 3'd1, 0, 4'd1);
    vecs[19] = mk(0, 32'h0,         8'b00000000, 1, 0, 3'd2, 0, 32'h0000_0000, 8'b00000000, 3'd0, 0, 4'd1);

    rst_n = 1'b0;
    drive(0, 32'h0, 8'h00, 0, 0, 3'd0);
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset fill", 32'(fill), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset out_z", out_z, 32'd0);
    chk("reset cnt_q", 32'(cnt_q), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      apply(i, vecs[i]);
    end

    // Inexact counter saturates at 2^4-1 while the FIFO streams through.
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h3F00_0000 + 32'(i), 8'b00000100, 1, 0, 3'd5);
      @(posedge clk);
      #1;
      chk($sformatf("sat inexact %0d", i), 32'(cnt_q), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk("sat fill", 32'(fill), 32'd1);

    // clr and push together: counter ends at 0, push still lands.
    drive(1, 32'h1111_1111, 8'b00000100, 0, 1, 3'd5);
    @(posedge clk);
    #1;
    chk("clr+push inexact", 32'(cnt_q), 32'd0);
    chk("clr+push fill", 32'(fill), 32'd2);
    cnt_sel = 3'd6;
    #1;
    chk("clr+push valid cnt", 32'(cnt_q), 32'd0);
    drive(0, 32'h0, 8'h00, 0, 0, 3'd6);

    // Asynchronous reset mid-cycle with two entries held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst fill", 32'(fill), 32'd0);
    chk("async rst overflow", 32'(overflow), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst out_z", out_z, 32'd0);
    chk("post rst valid cnt", 32'(cnt_q), 32'd0);
    chk("post rst fill", 32'(fill), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpmul_result_collector.md
Name: fpmul_result_collector

Overview:
Downstream stage of the single-precision FP multiplier (main_module). Captures each produced {z, status} pair into a small FIFO, which a consumer drains through a valid/ready handshake. Keeps saturating per-flag event counters for the multiplier status bits. Flags overflow when the multiplier produces a result while the FIFO is full, because the multiplier cannot be stalled.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of each status event counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a multiplier result is present this cycle.
- in_z, input, 32, multiplier result z.
- in_status, input, [0:7], multiplier status vector.
- out_valid, output, 1, FIFO head is valid.
- out_ready, input, 1, consumer accepts the head.
- out_z, output, 32, head result.
- out_status, output, [0:7], head status.
- fill, output, $clog2(DEPTH)+1, current occupancy.
- overflow, output, 1, sticky; a result was dropped.
- cnt_sel, input, 3, selects the counter shown on cnt_q.
- cnt_q, output, CNT_W, selected counter value; combinational read.
- clr, input, 1, synchronous clear of counters and overflow; FIFO contents are untouched.

Behaviour:
- Status bit map (status[0:7]): 0 zero, 1 inf, 2 nan, 3 tiny, 4 huge, 5 inexact, 6–7 reserved.
- Reset (rst_n low, asynchronous):
  - out_valid=0, fill=0, overflow=0, all counters=0.
  - out_z and out_status read 0 while the FIFO is empty.
  - Read/write pointers return to 0.
- Push: in_valid=1 and (fill<DEPTH, or a pop occurs in the same cycle) writes the entry at the write pointer. The entry is visible at out_* one cycle later if the FIFO was empty. Latency is 1 cycle; there is no fall-through.
- Pop: out_valid && out_ready advances the read pointer. out_* comes from the registered head, so no combinational path exists from in_* to out_*.
- Push and pop in the same cycle: fill is unchanged. When full, this is legal and is not an overflow.
- Overflow: in_valid=1, fill==DEPTH and no pop → the entry is dropped, overflow←1 (sticky until clr or reset), and counters are still updated.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill distinguishes full from empty.
- Counters:
  - Six counters (sel 0..5 = zero, inf, nan, tiny, huge, inexact).
  - On each in_valid, every counter whose status bit is 1 increments by 1.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - cnt_sel 6 returns the count of valid results (also saturating); cnt_sel 7 returns 0.
- clr:
  - Zeroes all counters and overflow on the next edge.
  - If in_valid is high in the same cycle, clr wins and the counters are set to 0, not 1.
  - The FIFO still accepts the push.
- Reset mid-operation: FIFO contents are discarded, out_valid drops immediately, counters are lost.
- Accepted values are not interpreted: every NaN payload, denormal and signed zero passes through bit-exact, except as stated under Optional Feature.

Optional Feature:
- Macro: FPMUL_COLLECT_NAN_CANON_EN.
- When defined: any entry pushed with status[2]=1 stores z as the canonical quiet NaN 32'h7FC0_0000, with sign forced to 0, regardless of in_z.
- When undefined: in_z is stored unmodified.
- Counters behave identically in both builds.

Decomposition:
- global_types package gains:
  - status bit index constants (ST_ZERO=0 … ST_INEXACT=5).
  - CANON_QNAN=32'h7FC0_0000.
  - a packed struct fpmul_result_t {logic [31:0] z; logic [0:7] status}, used as the FIFO word.
- One sub-module, sat_counter, with parameter W, inputs inc and clr, output q. It is instantiated seven times.

Test Plan:
- Reset, then push 3 results (z=3F800000 status 00000000; z=7F800000 status 01001000; z=00000000 status 10000000) with out_ready=0 → fill=3, out_z=3F800000; drain yields the results in order, then out_valid=0.
- With out_ready=0, push 5 results into DEPTH=4 → fill=4, overflow=1, the 5th entry is absent from the FIFO, cnt_sel=6 reads 5.
- FIFO full with push and pop in the same cycle → fill stays 4, overflow stays 0, out_* advances to the 2nd entry.
- Push 7FC00001 with status[2]=1 → nan counter=1; out_z is 7FC00001 in the default build, 7FC00000 when FPMUL_COLLECT_NAN_CANON_EN is defined.
- CNT_W=4, 20 pushes with the inexact bit set → cnt_q (sel 5) saturates at 15; then clr and a push in the same cycle → counter=0, fill increments.
- Assert rst_n low asynchronously mid-stream with fill=2 → out_valid=0, fill=0 and overflow=0 immediately, before the next clk edge.
